// File: rtl/nn_pkg.sv
// Shared fixed-point word type and FSM state encoding for the serializer/deserializer pair.
package nn_pkg;

    localparam int unsigned QSizeDefault = 16;

    typedef logic [QSizeDefault-1:0] q_word_t;

    typedef enum logic {
        StCollect,
        StFull
    } deser_state_e;

endpackage

// File: rtl/word_counter.sv
// Wrapping word counter (0..OUTPUT_SIZE-1) with a terminal-count flag for the deserializer.
module word_counter #(
    parameter int unsigned OUTPUT_SIZE = 4,
    parameter int unsigned COUNT_W     = $clog2(OUTPUT_SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [COUNT_W-1:0] count,
    output logic               last
);

    logic [COUNT_W-1:0] count_q, count_d;

    assign last  = (count_q == COUNT_W'(OUTPUT_SIZE - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = last ? '0 : count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/deserializer.sv
// Reassembles a stream of Q_SIZE-bit words into an OUTPUT_SIZE-word frame.
// Define DESERIALIZER_DOUBLE_BUFFER_EN for a separate output register (assembly continues while a frame waits).
module deserializer
    import nn_pkg::*;
#(
    parameter int unsigned OUTPUT_SIZE = 4,
    parameter int unsigned Q_SIZE      = QSizeDefault
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [Q_SIZE-1:0]                     serial_in,
    input  logic                                  serial_valid,
    output logic                                  serial_ready,
    output logic [OUTPUT_SIZE-1:0][Q_SIZE-1:0]    data_out,
    output logic                                  data_valid,
    input  logic                                  data_ready,
    output logic [$clog2(OUTPUT_SIZE+1)-1:0]      word_count
);

    localparam int unsigned CountW = $clog2(OUTPUT_SIZE + 1);

    logic                               accept;
    logic                               last_word;
    logic [OUTPUT_SIZE-1:0][Q_SIZE-1:0] asm_q, asm_d;

    assign accept = serial_valid && serial_ready;

    word_counter #(
        .OUTPUT_SIZE (OUTPUT_SIZE),
        .COUNT_W     (CountW)
    ) u_word_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .count (word_count),
        .last  (last_word)
    );

    // New words enter at the top and the frame shifts down, so word 0 ends at index 0.
    always_comb begin
        asm_d = asm_q;
        if (accept) begin
            asm_d = {serial_in, asm_q[OUTPUT_SIZE-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
        end else begin
            asm_q <= asm_d;
        end
    end

`ifdef DESERIALIZER_DOUBLE_BUFFER_EN

    logic [OUTPUT_SIZE-1:0][Q_SIZE-1:0] out_q;
    logic                               valid_q;

    // Only the completing word of the next frame waits on the pending one.
    assign serial_ready = !(last_word && valid_q && !data_ready);
    assign data_valid   = valid_q;
    assign data_out     = out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (accept && last_word) begin
            out_q   <= asm_d;
            valid_q <= 1'b1;
        end else if (data_ready) begin
            valid_q <= 1'b0;
        end
    end

`else

    deser_state_e state_q, state_d;

    assign serial_ready = (state_q == StCollect);
    assign data_valid   = (state_q == StFull);
    assign data_out     = asm_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: if (accept && last_word) state_d = StFull;
            StFull:    if (data_ready) state_d = StCollect;
            default:   state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

`endif

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer (OUTPUT_SIZE=4, Q_SIZE=8); honours DESERIALIZER_DOUBLE_BUFFER_EN.
module tb_deserializer;

    localparam int N = 4;
    localparam int Q = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [Q-1:0]      serial_in;
    logic              serial_valid;
    logic              serial_ready;
    logic [N-1:0][Q-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic [2:0]        word_count;

    int checks = 0;
    int errors = 0;

    // Reference model: words of the frame in progress, plus the pending output frame.
    logic [Q-1:0]   m_words[$];
    logic           m_valid;
    logic [N*Q-1:0] m_frame;

    always #5 clk = ~clk;

    deserializer #(
        .OUTPUT_SIZE (N),
        .Q_SIZE      (Q)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .serial_ready (serial_ready),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .word_count   (word_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready(input logic dr);
`ifdef DESERIALIZER_DOUBLE_BUFFER_EN
        return !(m_words.size() == N - 1 && m_valid && !dr);
`else
        return !m_valid;
`endif
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic r, input logic v, input logic [Q-1:0] w, input logic dr);
        logic acc;
        logic xfer;
        rst          = r;
        serial_valid = v;
        serial_in    = w;
        data_ready   = dr;
        #2;
        chk("serial_ready", 64'(serial_ready), 64'(model_ready(dr)));
        chk("data_valid", 64'(data_valid), 64'(m_valid));
        chk("word_count", 64'(word_count), 64'(m_words.size()));
        if (m_valid) chk("data_out", 64'(data_out), 64'(m_frame));
        if (r) begin
            m_words.delete();
            m_valid = 1'b0;
        end else begin
            acc  = v && model_ready(dr);
            xfer = m_valid && dr;
            if (acc) m_words.push_back(w);
            if (m_words.size() == N) begin
                for (int i = 0; i < N; i++) m_frame[i*Q +: Q] = m_words[i];
                m_words.delete();
                m_valid = 1'b1;
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        serial_valid = 1'b1;
        serial_in    = '0;
        data_ready   = 1'b0;
        m_valid      = 1'b0;
        m_frame      = '0;
        @(posedge clk);
        #1;

        // Reset held with serial_valid high
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        #2;
        chk("reset_data_out", 64'(data_out), 64'h0);
        chk("reset_ready", 64'(serial_ready), 64'h1);

        // Single frame on consecutive cycles, then hold
        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        step(1'b0, 1'b1, 8'h44, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("frame1", 64'(data_out), 64'h44332211);

        // Drain, then the same words with gaps, then a one-cycle handshake
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b0, 8'hEE, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        step(1'b0, 1'b0, 8'hEE, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        step(1'b0, 1'b0, 8'hEE, 1'b0);
        step(1'b0, 1'b1, 8'h44, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("frame_gaps", 64'(data_out), 64'h44332211);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Mid-frame reset discards the partial frame
        step(1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b1, 8'h88, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("frame_after_rst", 64'(data_out), 64'hA3A2A1A0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Back-to-back words with data_ready high
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 8'(i), 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Stall: eight words offered with data_ready low, then released
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b0, 1'b1, 8'h18, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 100) == 0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
